// File: rtl/servo_cmd_ramp.sv
// Servo command front end: PicoBlaze port writes set per-channel targets, currents slew at a fixed rate.
// Define SERVO_CMD_READBACK_EN to expose both current values on the port bus.
`timescale 1ns/1ps
module servo_cmd_ramp #(
    parameter int unsigned RAMP_DIV    = 50000,
    parameter int unsigned SLOT_CYCLES = 1601536,
`ifdef SERVO_CMD_READBACK_EN
    parameter logic [7:0]  CUR0_PORT   = 8'h13,
    parameter logic [7:0]  CUR1_PORT   = 8'h14,
`endif
    parameter logic [7:0]  CMD_PORT    = 8'h10,
    parameter logic [7:0]  CTRL_PORT   = 8'h11,
    parameter logic [7:0]  STATUS_PORT = 8'h12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       servo_select,
    output logic       direction,
    output logic [5:0] speed_angle,
    output logic [1:0] busy
);

    localparam int unsigned RW = $clog2(RAMP_DIV);
    localparam int unsigned SW = $clog2(SLOT_CYCLES);
    localparam int unsigned VW = 7;

    logic [RW-1:0]        ramp_cnt;
    logic [SW-1:0]        slot_cnt;
    logic signed [VW-1:0] tgt [2];
    logic signed [VW-1:0] cur [2];
    logic signed [VW-1:0] tgt_nxt [2];
    logic signed [VW-1:0] cur_nxt [2];
    logic                 imm;
    logic                 done;

    logic                 ramp_tick;
    logic                 slot_wrap;
    logic                 cmd_wr;
    logic                 ctrl_wr;
    logic                 stop_all;
    logic                 status_rd;
    logic                 cmd_ch;
    logic [VW-1:0]        mag_ext;
    logic signed [VW-1:0] cmd_val;
    logic [1:0]           step_hit;
    logic signed [VW-1:0] sel_val;
    logic [7:0]           rd_data;

    // Next-state for targets/currents: stop-all beats a command write, which beats a ramp step
    always_comb begin
        ramp_tick = (ramp_cnt == RW'(RAMP_DIV - 1));
        slot_wrap = (slot_cnt == SW'(SLOT_CYCLES - 1));
        cmd_wr    = write_strobe && (port_id == CMD_PORT);
        ctrl_wr   = write_strobe && (port_id == CTRL_PORT);
        stop_all  = ctrl_wr && out_port[1];
        status_rd = read_strobe && (port_id == STATUS_PORT);
        cmd_ch    = out_port[7];
        mag_ext   = {1'b0, out_port[5:0]};
        cmd_val   = out_port[6] ? mag_ext : -mag_ext;
        step_hit  = 2'b00;

        for (int unsigned i = 0; i < 2; i++) begin
            tgt_nxt[i] = tgt[i];
            cur_nxt[i] = cur[i];
            if (ramp_tick && (cur[i] != tgt[i])) begin
                cur_nxt[i]  = (cur[i] < tgt[i]) ? cur[i] + 7'sd1 : cur[i] - 7'sd1;
                step_hit[i] = (cur_nxt[i] == tgt[i]);
            end
        end

        if (stop_all) begin
            for (int unsigned i = 0; i < 2; i++) begin
                tgt_nxt[i] = '0;
                cur_nxt[i] = '0;
            end
            step_hit = 2'b00;
        end else if (cmd_wr) begin
            tgt_nxt[cmd_ch] = cmd_val;
            if (imm) begin
                cur_nxt[cmd_ch]  = cmd_val;
                step_hit[cmd_ch] = 1'b0;
            end
        end

        sel_val = cur[servo_select];

        rd_data = 8'h00;
        case (port_id)
            STATUS_PORT: rd_data = {servo_select, 4'b0000, done, busy};
`ifdef SERVO_CMD_READBACK_EN
            CUR0_PORT:   rd_data = {1'b0, cur[0]};
            CUR1_PORT:   rd_data = {1'b0, cur[1]};
`endif
            default:     rd_data = 8'h00;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ramp_cnt     <= '0;
            slot_cnt     <= '0;
            tgt          <= '{default: '0};
            cur          <= '{default: '0};
            imm          <= 1'b0;
            done         <= 1'b0;
            in_port      <= 8'h00;
            servo_select <= 1'b0;
            direction    <= 1'b0;
            speed_angle  <= 6'd0;
            busy         <= 2'b00;
        end else begin
            ramp_cnt     <= ramp_tick ? '0 : ramp_cnt + RW'(1);
            slot_cnt     <= slot_wrap ? '0 : slot_cnt + SW'(1);
            servo_select <= servo_select ^ slot_wrap;
            tgt          <= tgt_nxt;
            cur          <= cur_nxt;
            if (ctrl_wr) begin
                imm <= out_port[0];
            end
            if (|step_hit) begin
                done <= 1'b1;
            end else if (status_rd) begin
                done <= 1'b0;
            end
            in_port     <= rd_data;
            direction   <= (sel_val > 7'sd0);
            speed_angle <= sel_val[VW-1] ? 6'(-sel_val) : sel_val[5:0];
            busy        <= {cur[1] != tgt[1], cur[0] != tgt[0]};
        end
    end

endmodule

// File: doc/servo_cmd_ramp.md
Name: servo_cmd_ramp

Overview:
Command front end between the PicoBlaze port bus and the servo PWM controller. Holds per-servo targets written by firmware and slews each servo's current value toward its target at a fixed rate. Alternates the presented channel on a slot timer so both servos are refreshed. Drives the controller's direction / speed_angle[5:0] / servo_select inputs and returns status on in_port.

Parameters:
CMD_PORT, 8'h10, port_id for servo command writes
CTRL_PORT, 8'h11, port_id for control writes
STATUS_PORT, 8'h12, port_id for status reads
CUR0_PORT, 8'h13, readback of channel 0 current value (optional feature)
CUR1_PORT, 8'h14, readback of channel 1 current value (optional feature)
RAMP_DIV, 50000, clk cycles per ramp step (5 ms at 10 MHz); must be >= 2
SLOT_CYCLES, 1601536, clk cycles per output slot (one 4096x391 PWM frame)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
port_id  in  8  PicoBlaze port address
out_port  in  8  PicoBlaze write data
write_strobe  in  1  PicoBlaze write qualifier
read_strobe  in  1  PicoBlaze read qualifier
in_port  out  8  registered read data
servo_select  out  1  active channel to controller (0 full-rotation, 1 normal)
direction  out  1  sign of active channel current value
speed_angle  out  6  magnitude of active channel current value
busy  out  2  per channel: current != target

Behaviour:
- Reset (async, active-high): targets, currents, ramp and slot counters, immediate flag, done flag = 0; in_port = 8'h00, servo_select = 0, direction = 0, speed_angle = 0, busy = 2'b00.
- Value format: 7-bit two's complement, range -63..+63. Command byte {ch, dir, mag[5:0]} maps to +mag if dir=1, else -mag; mag=0 gives 0 regardless of dir.
- CMD write (write_strobe & port_id==CMD_PORT): target[out_port[7]] updated next edge. If immediate=1, current[ch] loads the same value on the same edge.
- CTRL write: bit0 -> immediate flag. bit1 = stop-all: both targets and currents -> 0 next edge; the bit is not stored.
- Ramp tick: counter 0..RAMP_DIV-1; tick on the cycle it equals RAMP_DIV-1, then wraps to 0. On tick, each channel independently: current < target -> +1; current > target -> -1; equal -> hold. Zero-crossing passes through 0, one step per tick.
- Priority in one cycle: stop-all > CMD write (immediate) > ramp step for the addressed channel. A step uses the pre-write target; the new target applies from the next tick. The unaddressed channel still steps.
- Slot: counter 0..SLOT_CYCLES-1; servo_select toggles on wrap.
- Outputs are registered from current[servo_select]: direction = (cur > 0); speed_angle = |cur|; 0 -> dir 0, mag 0. Latency: one clk after current or servo_select changes.
- busy[i] = (current[i] != target[i]), registered.
- done flag (sticky): set on the cycle either channel's current reaches its target by a ramp step. Cleared by read_strobe & port_id==STATUS_PORT; set wins over simultaneous clear.
- in_port is registered every cycle from port_id: STATUS_PORT -> {servo_select, 4'b0, done, busy[1], busy[0]}; other addresses -> 8'h00. A status read returns done as it was before the clear.
- Writes to undecoded ports are ignored.
- Reset mid-ramp: everything returns to reset values immediately; no step completes.

Optional Feature:
SERVO_CMD_READBACK_EN. When defined: port_id CUR0_PORT / CUR1_PORT return {1'b0, current[i]} (7-bit two's complement) on in_port. When undefined: those addresses return 8'h00 and no readback mux is built.

Test Plan:
- Reset with non-zero pending stimulus -> all outputs 0, busy=00, in_port=00.
- RAMP_DIV=4, SLOT_CYCLES=16; write CMD 8'h45 (ch0, +5) -> busy[0]=1; current steps 1..5, one step per 4 clk; done sets at 5; busy[0]=0. With servo_select=0: direction=1, speed_angle=5.
- ch0 at +2, write 8'h03 (ch0, -3) -> steps +1, 0, -1, -2, -3; at 0 outputs dir=0, mag=0; ends dir=0, mag=3.
- CTRL 8'h01, then CMD 8'hFF (ch1, +63) -> current[1]=+63 next edge, busy[1]=0; after slot wrap, servo_select=1, speed_angle=63.
- Both channels ramping; CTRL 8'h02 on a tick cycle -> both currents/targets 0 next edge, no step applied.
- Status read with done=1 and same-cycle completion on other channel -> in_port shows done=1; done remains set afterward (set wins).
